// File: rtl/dds_sweep_ctrl.sv
// Stepped linear frequency sweep sequencer for the DDS phase-accumulator core.
// Holds a shadow copy of the sweep configuration and paces fcword/pcword updates by a dwell counter.
module dds_sweep_ctrl #(
  parameter int FW = 32,
  parameter int PW = 12,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [FW-1:0] cfg_f_start,
  input  logic [FW-1:0] cfg_f_stop,
  input  logic [FW-1:0] cfg_f_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [PW-1:0] cfg_phase,
  input  logic [1:0]    cfg_mode,
  input  logic          start,
  input  logic          abort,
  output logic [FW-1:0] fcword,
  output logic [PW-1:0] pcword,
  output logic          fc_upd,
  output logic          busy,
  output logic          done,
  output logic [15:0]   pass_cnt
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [1:0] MODE_SAW = 2'd1;
  localparam logic [1:0] MODE_TRI = 2'd2;

  state_t        state_r;
  logic          dir_down_r;
  logic [DW-1:0] dwell_cnt_r;
  logic          cfg_loaded_r;
  logic          cfg_ready_r;
  logic [FW-1:0] f_start_r;
  logic [FW-1:0] f_stop_r;
  logic [FW-1:0] f_step_r;
  logic [DW-1:0] dwell_r;
  logic [PW-1:0] phase_r;
  logic [1:0]    mode_r;
  logic [FW-1:0] fcword_r;
  logic [PW-1:0] pcword_r;
  logic          fc_upd_r;
  logic          busy_r;
  logic          done_r;
  logic [15:0]   pass_cnt_r;

  logic          hs_s;
  logic [FW-1:0] ent_f_start_s;
  logic [PW-1:0] ent_phase_s;
  logic [DW-1:0] ent_dwell_s;
  logic [FW:0]   sum_s;
  logic [FW:0]   diff_s;
  logic [FW-1:0] up_next_s;
  logic [FW-1:0] down_next_s;
  logic          degen_s;
  logic          pass_end_s;
  logic          finish_s;
  logic          flip_s;
  logic          upd_s;
  logic [FW-1:0] nxt_fc_s;

  assign hs_s = cfg_valid & cfg_ready_r;

  // A config accepted in the same cycle as start is the one the sweep begins with.
  always_comb begin
    if (hs_s) begin
      ent_f_start_s = cfg_f_start;
      ent_phase_s   = cfg_phase;
      ent_dwell_s   = cfg_dwell;
    end else begin
      ent_f_start_s = f_start_r;
      ent_phase_s   = phase_r;
      ent_dwell_s   = dwell_r;
    end
  end

  // Saturating next-step values; the extra MSB catches carry/borrow so nothing wraps.
  always_comb begin
    sum_s   = {1'b0, fcword_r} + {1'b0, f_step_r};
    diff_s  = {1'b0, fcword_r} - {1'b0, f_step_r};
    degen_s = (f_step_r == {FW{1'b0}}) || (f_start_r >= f_stop_r);
    if (sum_s[FW] || (sum_s[FW-1:0] > f_stop_r)) begin
      up_next_s = f_stop_r;
    end else begin
      up_next_s = sum_s[FW-1:0];
    end
    if (diff_s[FW] || (diff_s[FW-1:0] < f_start_r)) begin
      down_next_s = f_start_r;
    end else begin
      down_next_s = diff_s[FW-1:0];
    end
  end

  // Step decision applied at each dwell expiry.
  always_comb begin
    pass_end_s = 1'b0;
    finish_s   = 1'b0;
    flip_s     = 1'b0;
    upd_s      = 1'b0;
    nxt_fc_s   = fcword_r;
    if (degen_s) begin
      pass_end_s = 1'b1;
      case (mode_r)
        MODE_SAW: finish_s = 1'b0;
        MODE_TRI: finish_s = 1'b0;
        default:  finish_s = 1'b1;
      endcase
    end else if (!dir_down_r) begin
      if (fcword_r == f_stop_r) begin
        pass_end_s = 1'b1;
        case (mode_r)
          MODE_SAW: begin
            nxt_fc_s = f_start_r;
            upd_s    = 1'b1;
          end
          MODE_TRI: begin
            flip_s   = 1'b1;
            nxt_fc_s = down_next_s;
            upd_s    = 1'b1;
          end
          default: finish_s = 1'b1;
        endcase
      end else begin
        nxt_fc_s = up_next_s;
        upd_s    = 1'b1;
      end
    end else begin
      if (fcword_r == f_start_r) begin
        pass_end_s = 1'b1;
        case (mode_r)
          MODE_TRI: begin
            flip_s   = 1'b1;
            nxt_fc_s = up_next_s;
            upd_s    = 1'b1;
          end
          default: finish_s = 1'b1;
        endcase
      end else begin
        nxt_fc_s = down_next_s;
        upd_s    = 1'b1;
      end
    end
  end

  // Sweep FSM, shadow config registers and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      dir_down_r   <= 1'b0;
      dwell_cnt_r  <= {DW{1'b0}};
      cfg_loaded_r <= 1'b0;
      cfg_ready_r  <= 1'b1;
      f_start_r    <= {FW{1'b0}};
      f_stop_r     <= {FW{1'b0}};
      f_step_r     <= {FW{1'b0}};
      dwell_r      <= {DW{1'b0}};
      phase_r      <= {PW{1'b0}};
      mode_r       <= 2'd0;
      fcword_r     <= {FW{1'b0}};
      pcword_r     <= {PW{1'b0}};
      fc_upd_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_cnt_r   <= 16'd0;
    end else begin
      fc_upd_r <= 1'b0;
      done_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
            f_start_r    <= cfg_f_start;
            f_stop_r     <= cfg_f_stop;
            f_step_r     <= cfg_f_step;
            dwell_r      <= cfg_dwell;
            phase_r      <= cfg_phase;
            mode_r       <= cfg_mode;
            cfg_loaded_r <= 1'b1;
          end
          if (start && !abort && cfg_loaded_r) begin
            state_r     <= ST_RUN;
            fcword_r    <= ent_f_start_s;
            pcword_r    <= ent_phase_s;
            fc_upd_r    <= 1'b1;
            dir_down_r  <= 1'b0;
            dwell_cnt_r <= ent_dwell_s;
            pass_cnt_r  <= 16'd0;
            busy_r      <= 1'b1;
            cfg_ready_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            cfg_ready_r <= 1'b1;
          end else if (dwell_cnt_r == {DW{1'b0}}) begin
            dwell_cnt_r <= dwell_r;
            fcword_r    <= nxt_fc_s;
            fc_upd_r    <= upd_s;
            if (pass_end_s) begin
              pass_cnt_r <= pass_cnt_r + 16'd1;
            end
            if (flip_s) begin
              dir_down_r <= ~dir_down_r;
            end
            if (finish_s) begin
              state_r     <= ST_IDLE;
              done_r      <= 1'b1;
              busy_r      <= 1'b0;
              cfg_ready_r <= 1'b1;
            end
          end else begin
            dwell_cnt_r <= dwell_cnt_r - DW'(1);
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          cfg_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_r;
  assign fcword    = fcword_r;
  assign pcword    = pcword_r;
  assign fc_upd    = fc_upd_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass_cnt  = pass_cnt_r;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: single, triangle, sawtooth, abort, reset and degenerate sweeps.
// Inputs change just after the falling edge; outputs are checked at the falling edge.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_f_start;
  logic [31:0] cfg_f_stop;
  logic [31:0] cfg_f_step;
  logic [23:0] cfg_dwell;
  logic [11:0] cfg_phase;
  logic [1:0]  cfg_mode;
  logic        start;
  logic        abort;
  logic [31:0] fcword;
  logic [11:0] pcword;
  logic        fc_upd;
  logic        busy;
  logic        done;
  logic [15:0] pass_cnt;

  int checks = 0;
  int errors = 0;

  dds_sweep_ctrl #(.FW(32), .PW(12), .DW(24)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
    .cfg_dwell(cfg_dwell), .cfg_phase(cfg_phase), .cfg_mode(cfg_mode),
    .start(start), .abort(abort), .fcword(fcword), .pcword(pcword),
    .fc_upd(fc_upd), .busy(busy), .done(done), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_cfg(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                          input logic [23:0] dw, input logic [11:0] ph, input logic [1:0] md);
    chk("cfg_ready_idle", cfg_ready, 1);
    cfg_f_start = fs; cfg_f_stop = fe; cfg_f_step = st;
    cfg_dwell = dw; cfg_phase = ph; cfg_mode = md;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [31:0] exp_fc [0:8];
  logic [15:0] exp_pc [0:8];
  logic        exp_up [0:8];

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_f_start = 32'd0; cfg_f_stop = 32'd0; cfg_f_step = 32'd0;
    cfg_dwell = 24'd0; cfg_phase = 12'd0; cfg_mode = 2'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_fcword", fcword, 0);
    chk("rst_pcword", pcword, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fc_upd", fc_upd, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: single 100..400 step 100 dwell 3
    load_cfg(32'd100, 32'd400, 32'd100, 24'd3, 12'h5A5, 2'd0);
    do_start();
    chk("t1_pcword", pcword, 12'h5A5);
    chk("t1_busy", busy, 1);
    chk("t1_cfg_ready_busy", cfg_ready, 0);
    for (int c = 0; c < 16; c++) begin
      chk("t1_fcword", fcword, 100 + 100 * (c / 4));
      chk("t1_fc_upd", fc_upd, (c % 4) == 0);
      chk("t1_no_done", done, 0);
      @(negedge clk);
    end
    chk("t1_done", done, 1);
    chk("t1_busy_fall", busy, 0);
    chk("t1_pass_cnt", pass_cnt, 1);
    chk("t1_fc_hold", fcword, 400);
    chk("t1_no_upd", fc_upd, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);

    // Test 2: clamp to stop with dwell 0
    load_cfg(32'd0, 32'd250, 32'd100, 24'd0, 12'd0, 2'd0);
    do_start();
    exp_fc[0] = 32'd0; exp_fc[1] = 32'd100; exp_fc[2] = 32'd200; exp_fc[3] = 32'd250;
    for (int i = 0; i < 4; i++) begin
      chk("t2_fcword", fcword, exp_fc[i]);
      chk("t2_fc_upd", fc_upd, 1);
      @(negedge clk);
    end
    chk("t2_done", done, 1);
    chk("t2_busy", busy, 0);
    chk("t2_fc_hold", fcword, 250);

    // Test 3: triangle 0..200 step 100, then abort
    load_cfg(32'd0, 32'd200, 32'd100, 24'd0, 12'd7, 2'd2);
    do_start();
    exp_fc[0] = 32'd0;   exp_fc[1] = 32'd100; exp_fc[2] = 32'd200; exp_fc[3] = 32'd100;
    exp_fc[4] = 32'd0;   exp_fc[5] = 32'd100; exp_fc[6] = 32'd200;
    exp_pc[0] = 16'd0; exp_pc[1] = 16'd0; exp_pc[2] = 16'd0; exp_pc[3] = 16'd1;
    exp_pc[4] = 16'd1; exp_pc[5] = 16'd2; exp_pc[6] = 16'd2;
    for (int i = 0; i < 7; i++) begin
      chk("t3_fcword", fcword, exp_fc[i]);
      chk("t3_pass_cnt", pass_cnt, exp_pc[i]);
      chk("t3_fc_upd", fc_upd, 1);
      @(negedge clk);
    end
    chk("t3_fcword_end", fcword, 100);
    chk("t3_pass_cnt_end", pass_cnt, 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_abort_busy", busy, 0);
    chk("t3_abort_hold", fcword, 100);
    chk("t3_abort_pass", pass_cnt, 3);
    chk("t3_abort_upd", fc_upd, 0);
    chk("t3_abort_done", done, 0);

    // Test 5: abort after the second step of test 1
    load_cfg(32'd100, 32'd400, 32'd100, 24'd3, 12'h5A5, 2'd0);
    do_start();
    repeat (4) @(negedge clk);
    chk("t5_step2", fcword, 200);
    chk("t5_step2_upd", fc_upd, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_hold", fcword, 200);
    for (int i = 0; i < 6; i++) begin
      chk("t5_no_done", done, 0);
      chk("t5_no_upd", fc_upd, 0);
      @(negedge clk);
    end
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("t5_abort_start_busy", busy, 0);
    chk("t5_abort_start_upd", fc_upd, 0);

    // Test 4: sawtooth near the top of the range, dwell 1
    load_cfg(32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 24'd1, 12'd0, 2'd1);
    do_start();
    exp_fc[0] = 32'hFFFFFF00; exp_fc[1] = 32'hFFFFFF00; exp_fc[2] = 32'hFFFFFF80;
    exp_fc[3] = 32'hFFFFFF80; exp_fc[4] = 32'hFFFFFFFF; exp_fc[5] = 32'hFFFFFFFF;
    exp_fc[6] = 32'hFFFFFF00; exp_fc[7] = 32'hFFFFFF00; exp_fc[8] = 32'hFFFFFF80;
    for (int i = 0; i < 9; i++) begin
      exp_up[i] = (i % 2) == 0;
      chk("t4_fcword", fcword, exp_fc[i]);
      chk("t4_fc_upd", fc_upd, exp_up[i]);
      chk("t4_pass_cnt", pass_cnt, (i >= 6) ? 1 : 0);
      @(negedge clk);
    end
    chk("t4_hold", fcword, 32'hFFFFFF80);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_start_ignored_fc", fcword, 32'hFFFFFFFF);
    chk("t4_start_ignored_pass", pass_cnt, 1);
    chk("t4_busy", busy, 1);
    cfg_valid = 1'b1;
    chk("t4_cfg_stall", cfg_ready, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("t4_cfg_stall2", cfg_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_rst_fcword", fcword, 0);
    chk("t4_rst_pcword", pcword, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_pass", pass_cnt, 0);
    chk("t4_rst_upd", fc_upd, 0);
    chk("t4_rst_ready", cfg_ready, 1);

    // Test 6: start with no loaded config, then zero-step single sweep
    do_start();
    chk("t6_noload_busy", busy, 0);
    chk("t6_noload_upd", fc_upd, 0);
    chk("t6_noload_fc", fcword, 0);
    load_cfg(32'd500, 32'd0, 32'd0, 24'd9, 12'd3, 2'd0);
    do_start();
    chk("t6_fcword", fcword, 500);
    chk("t6_fc_upd", fc_upd, 1);
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      chk("t6_hold", fcword, 500);
      chk("t6_no_upd", fc_upd, 0);
      chk("t6_no_done", done, 0);
      @(negedge clk);
    end
    chk("t6_done", done, 1);
    chk("t6_busy", busy, 0);
    chk("t6_pass_cnt", pass_cnt, 1);
    chk("t6_final_fc", fcword, 500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
